// File: rtl/qbert_pkg.sv
// Shared types and pyramid geometry for the Qbert movement logic.
package qbert_pkg;

    typedef enum logic [1:0] {
        UP_LEFT    = 2'd0,
        UP_RIGHT   = 2'd1,
        DOWN_LEFT  = 2'd2,
        DOWN_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        HOP,
        FALL
    } state_t;

    localparam int X_ORIGIN = 400;
    localparam int Y_ORIGIN = 200;
    localparam int ROW_DX   = 50;
    localparam int ROW_DY   = 150;
    localparam int YDIAG    = 90;

endpackage

// File: rtl/qbert_cube_coord.sv
// Combinational (row, col) -> (x, y) map of the spot Qbert stands on for a cube.
module qbert_cube_coord
    import qbert_pkg::*;
#(
    parameter int X_ORIGIN = qbert_pkg::X_ORIGIN,
    parameter int Y_ORIGIN = qbert_pkg::Y_ORIGIN,
    parameter int ROW_DX   = qbert_pkg::ROW_DX,
    parameter int ROW_DY   = qbert_pkg::ROW_DY,
    parameter int YDIAG    = qbert_pkg::YDIAG
) (
    input  logic [2:0]  row,
    input  logic [2:0]  col,
    output logic [10:0] x,
    output logic [9:0]  y
);

    logic signed [11:0] row_s;
    logic signed [11:0] col_s;

    assign row_s = signed'({9'd0, row});
    assign col_s = signed'({9'd0, col});

    // Arithmetic is 12-bit signed; the cast keeps only the pixel-width low bits.
    assign x = 11'(12'(X_ORIGIN) + (col_s + col_s - row_s) * 12'(ROW_DX));
    assign y = 10'(12'(Y_ORIGIN) + row_s * 12'(ROW_DY) + 12'(YDIAG));

endmodule

// File: rtl/qbert_hop_ctrl.sv
// Qbert hop sequencer: accepts one hop at a time, animates it over whole frames,
// and handles falls off the pyramid with a timed respawn at the apex.
module qbert_hop_ctrl
    import qbert_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int X_ORIGIN    = qbert_pkg::X_ORIGIN,
    parameter int Y_ORIGIN    = qbert_pkg::Y_ORIGIN,
    parameter int ROW_DX      = qbert_pkg::ROW_DX,
    parameter int ROW_DY      = qbert_pkg::ROW_DY,
    parameter int YDIAG       = qbert_pkg::YDIAG,
    parameter int HOP_FRAMES  = 8,
    parameter int LIFT        = 20,
    parameter int FALL_FRAMES = 16,
    parameter int FALL_DY     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_dir,
    output logic        cmd_ready,
    output logic [10:0] qbert_x,
    output logic [9:0]  qbert_y,
    output logic [2:0]  cube_row,
    output logic [2:0]  cube_col,
    output logic        landed,
    output logic        fell,
    output logic        busy
);

    localparam int HOP_SHIFT = $clog2(HOP_FRAMES);
    localparam int KW = $clog2((FALL_FRAMES > HOP_FRAMES ? FALL_FRAMES : HOP_FRAMES) + 1);
    localparam logic [10:0] HOME_X = 11'(X_ORIGIN);
    localparam logic [9:0]  HOME_Y = 10'(Y_ORIGIN + YDIAG);
    localparam logic signed [4:0] ROWS_S = 5'(ROWS);

    state_t            state, state_next;
    logic [2:0]        row, col, row_next, col_next;
    logic [2:0]        dest_row, dest_col, dest_row_next, dest_col_next;
    logic [KW-1:0]     k, k_next, k_inc;
    logic [10:0]       x_next, src_x, dest_x;
    logic [9:0]        y_next, src_y, dest_y;
    logic              landed_next, fell_next;
    logic signed [4:0] step_r, step_c, new_r, new_c;
    logic              off_pyramid;
    logic signed [15:0] dx_w, dy_w, k_w, src_x_w, src_y_w;
    logic [10:0]       fall_sum;

    qbert_cube_coord #(
        .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .ROW_DX(ROW_DX),
        .ROW_DY(ROW_DY), .YDIAG(YDIAG)
    ) u_src_coord (
        .row(row), .col(col), .x(src_x), .y(src_y)
    );

    qbert_cube_coord #(
        .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .ROW_DX(ROW_DX),
        .ROW_DY(ROW_DY), .YDIAG(YDIAG)
    ) u_dest_coord (
        .row(dest_row), .col(dest_col), .x(dest_x), .y(dest_y)
    );

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cube_row  = row;
    assign cube_col  = col;

    assign k_inc    = k + KW'(1);
    assign k_w      = signed'(16'(k_inc));
    assign src_x_w  = signed'({5'd0, src_x});
    assign src_y_w  = signed'({6'd0, src_y});
    assign dx_w     = signed'({5'd0, dest_x}) - src_x_w;
    assign dy_w     = signed'({6'd0, dest_y}) - src_y_w;
    assign fall_sum = {1'b0, qbert_y} + 11'(FALL_DY);

    always_comb begin
        step_r = '0;
        step_c = '0;
        case (dir_t'(cmd_dir))
            UP_LEFT:    begin step_r = -5'sd1; step_c = -5'sd1; end
            UP_RIGHT:   step_r = -5'sd1;
            DOWN_LEFT:  step_r = 5'sd1;
            DOWN_RIGHT: begin step_r = 5'sd1;  step_c = 5'sd1;  end
            default:    ;
        endcase
        new_r = signed'({2'd0, row}) + step_r;
        new_c = signed'({2'd0, col}) + step_c;
        off_pyramid = (new_r < 5'sd0) || (new_r >= ROWS_S) ||
                      (new_c < 5'sd0) || (new_c > new_r);
    end

    // A tick arriving with the accepting edge is dropped; frame counting starts next tick.
    always_comb begin
        state_next    = state;
        row_next      = row;
        col_next      = col;
        dest_row_next = dest_row;
        dest_col_next = dest_col;
        k_next        = k;
        x_next        = qbert_x;
        y_next        = qbert_y;
        landed_next   = 1'b0;
        fell_next     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    dest_row_next = new_r[2:0];
                    dest_col_next = new_c[2:0];
                    k_next        = '0;
                    state_next    = off_pyramid ? FALL : HOP;
                end
            end
            HOP: begin
                if (frame_tick) begin
                    k_next = k_inc;
                    if (k_inc == KW'(HOP_FRAMES)) begin
                        x_next      = dest_x;
                        y_next      = dest_y;
                        row_next    = dest_row;
                        col_next    = dest_col;
                        landed_next = 1'b1;
                        k_next      = '0;
                        state_next  = IDLE;
                    end else begin
                        x_next = 11'(src_x_w + ((dx_w * k_w) >>> HOP_SHIFT));
                        y_next = 10'(src_y_w + ((dy_w * k_w) >>> HOP_SHIFT) - 16'(LIFT));
                    end
                end
            end
            FALL: begin
                if (frame_tick) begin
                    k_next = k_inc;
                    if (k_inc == KW'(FALL_FRAMES)) begin
                        x_next     = HOME_X;
                        y_next     = HOME_Y;
                        row_next   = '0;
                        col_next   = '0;
                        fell_next  = 1'b1;
                        k_next     = '0;
                        state_next = IDLE;
                    end else begin
                        y_next = (fall_sum > 11'd1023) ? 10'd1023 : fall_sum[9:0];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            dest_row <= '0;
            dest_col <= '0;
            k        <= '0;
            qbert_x  <= HOME_X;
            qbert_y  <= HOME_Y;
            landed   <= 1'b0;
            fell     <= 1'b0;
        end else begin
            state    <= state_next;
            row      <= row_next;
            col      <= col_next;
            dest_row <= dest_row_next;
            dest_col <= dest_col_next;
            k        <= k_next;
            qbert_x  <= x_next;
            qbert_y  <= y_next;
            landed   <= landed_next;
            fell     <= fell_next;
        end
    end

endmodule

// File: tb/tb_qbert_hop_ctrl.sv
// Scoreboard bench for qbert_hop_ctrl: a cycle model queues expected outputs per
// driven cycle and each scenario task pops and compares them after the edge.
module tb_qbert_hop_ctrl;
    import qbert_pkg::*;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic        cmd_valid;
    logic [1:0]  cmd_dir;
    logic        cmd_ready;
    logic [10:0] qbert_x;
    logic [9:0]  qbert_y;
    logic [2:0]  cube_row;
    logic [2:0]  cube_col;
    logic        landed;
    logic        fell;
    logic        busy;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [3:0]  flags;
    } obs_t;

    obs_t sb[$];
    obs_t exp_o;
    obs_t got_o;
    int   n_vec;
    int   n_miss;

    int m_state, m_r, m_c, m_dr, m_dc, m_k, m_x, m_y;
    bit m_landed, m_fell;

    qbert_hop_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_ready(cmd_ready),
        .qbert_x(qbert_x), .qbert_y(qbert_y), .cube_row(cube_row),
        .cube_col(cube_col), .landed(landed), .fell(fell), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pos_x(int r, int c);
        return 400 + (2 * c - r) * 50;
    endfunction

    function automatic int pos_y(int r);
        return 290 + 150 * r;
    endfunction

    task automatic model_step(bit rst, bit valid, int dir, bit tick);
        int nr, nc, sx, sy;
        m_landed = 0;
        m_fell   = 0;
        if (rst) begin
            m_state = 0; m_r = 0; m_c = 0; m_k = 0; m_x = 400; m_y = 290;
            return;
        end
        case (m_state)
            0: if (valid) begin
                nr = m_r + ((dir >= 2) ? 1 : -1);
                nc = m_c + ((dir == 0) ? -1 : ((dir == 3) ? 1 : 0));
                m_dr = nr; m_dc = nc; m_k = 0;
                m_state = (nr < 0 || nr >= 4 || nc < 0 || nc > nr) ? 2 : 1;
            end
            1: if (tick) begin
                m_k++;
                if (m_k == 8) begin
                    m_x = pos_x(m_dr, m_dc); m_y = pos_y(m_dr);
                    m_r = m_dr; m_c = m_dc; m_k = 0; m_landed = 1; m_state = 0;
                end else begin
                    sx = pos_x(m_r, m_c); sy = pos_y(m_r);
                    m_x = sx + (((pos_x(m_dr, m_dc) - sx) * m_k) >>> 3);
                    m_y = sy + (((pos_y(m_dr) - sy) * m_k) >>> 3) - 20;
                end
            end
            2: if (tick) begin
                m_k++;
                if (m_k == 16) begin
                    m_x = 400; m_y = 290; m_r = 0; m_c = 0;
                    m_k = 0; m_fell = 1; m_state = 0;
                end else begin
                    m_y = (m_y + 32 > 1023) ? 1023 : m_y + 32;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.x = 11'(m_x);
        o.y = 10'(m_y);
        o.row = 3'(m_r);
        o.col = 3'(m_c);
        o.flags = {m_state == 0, m_state != 0, m_landed, m_fell};
        return o;
    endfunction

    function automatic obs_t dut_obs();
        return {qbert_x, qbert_y, cube_row, cube_col, cmd_ready, busy, landed, fell};
    endfunction

    // Drive one cycle, queue the model's expectation, and land #1 past the edge.
    task automatic applyStimulus(bit rst, bit valid, logic [1:0] dir, bit tick);
        reset = rst; cmd_valid = valid; cmd_dir = dir; frame_tick = tick;
        model_step(rst, valid, int'(dir), tick);
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
        reset = 1'b0; cmd_valid = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 62; i++) begin
            applyStimulus(i < 2, 1'b0, 2'd0, (i >= 2) && (i % 3 == 0));
            exp_o = sb.pop_front(); got_o = dut_obs(); n_vec++;
            if (got_o !== exp_o) begin
                n_miss++;
                $display("[TB] FAIL reset cyc%0d: got x=%0d y=%0d rc=%0d/%0d flags=%b, expected x=%0d y=%0d rc=%0d/%0d flags=%b",
                         i, got_o.x, got_o.y, got_o.row, got_o.col, got_o.flags,
                         exp_o.x, exp_o.y, exp_o.row, exp_o.col, exp_o.flags);
            end
            if (i == 1) begin
                n_vec++;
                if (qbert_x !== 11'd400 || qbert_y !== 10'd290 || cmd_ready !== 1'b1) begin
                    n_miss++;
                    $display("[TB] FAIL reset_home: got (%0d,%0d) ready=%b, expected (400,290) ready=1", qbert_x, qbert_y, cmd_ready);
                end
            end
        end
    endtask

    task automatic test_hop();
        int ticks;
        ticks = 0;
        for (int i = 0; i < 27; i++) begin
            applyStimulus(1'b0, i == 0, DOWN_RIGHT, (i > 0) && (i % 3 == 0));
            if ((i > 0) && (i % 3 == 0)) ticks++;
            exp_o = sb.pop_front(); got_o = dut_obs(); n_vec++;
            if (got_o !== exp_o) begin
                n_miss++;
                $display("[TB] FAIL hop cyc%0d: got x=%0d y=%0d rc=%0d/%0d flags=%b, expected x=%0d y=%0d rc=%0d/%0d flags=%b",
                         i, got_o.x, got_o.y, got_o.row, got_o.col, got_o.flags,
                         exp_o.x, exp_o.y, exp_o.row, exp_o.col, exp_o.flags);
            end
            if (i == 12) begin
                n_vec++;
                if (qbert_x !== 11'd425 || qbert_y !== 10'd345) begin
                    n_miss++;
                    $display("[TB] FAIL hop_mid: got (%0d,%0d), expected (425,345)", qbert_x, qbert_y);
                end
            end
            if (i == 24) begin
                n_vec++;
                if (qbert_x !== 11'd450 || qbert_y !== 10'd440 || landed !== 1'b1 || cube_row !== 3'd1) begin
                    n_miss++;
                    $display("[TB] FAIL hop_land: got (%0d,%0d) landed=%b row=%0d, expected (450,440) landed=1 row=1 after %0d ticks",
                             qbert_x, qbert_y, landed, cube_row, ticks);
                end
            end
        end
    endtask

    task automatic test_fall();
        for (int i = 0; i < 52; i++) begin
            applyStimulus(i == 0, i == 1, UP_LEFT, (i > 1) && (i % 3 == 1));
            exp_o = sb.pop_front(); got_o = dut_obs(); n_vec++;
            if (got_o !== exp_o) begin
                n_miss++;
                $display("[TB] FAIL fall cyc%0d: got x=%0d y=%0d rc=%0d/%0d flags=%b, expected x=%0d y=%0d rc=%0d/%0d flags=%b",
                         i, got_o.x, got_o.y, got_o.row, got_o.col, got_o.flags,
                         exp_o.x, exp_o.y, exp_o.row, exp_o.col, exp_o.flags);
            end
            if (i == 4) begin
                n_vec++;
                if (qbert_x !== 11'd400 || qbert_y !== 10'd322) begin
                    n_miss++;
                    $display("[TB] FAIL fall_first: got (%0d,%0d), expected (400,322)", qbert_x, qbert_y);
                end
            end
            if (i == 49) begin
                n_vec++;
                if (fell !== 1'b1 || qbert_y !== 10'd290) begin
                    n_miss++;
                    $display("[TB] FAIL fall_respawn: got fell=%b y=%0d, expected fell=1 y=290", fell, qbert_y);
                end
            end
        end
    endtask

    task automatic test_fall_saturate();
        logic [1:0] d;
        int         n_ticks;
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        void'(sb.pop_front());
        for (int h = 0; h < 4; h++) begin
            d = (h < 3) ? DOWN_LEFT : DOWN_RIGHT;
            n_ticks = (h < 3) ? 8 : 16;
            for (int i = 0; i <= 2 * n_ticks; i++) begin
                applyStimulus(1'b0, i == 0, d, (i > 0) && (i % 2 == 0));
                exp_o = sb.pop_front(); got_o = dut_obs(); n_vec++;
                if (got_o !== exp_o) begin
                    n_miss++;
                    $display("[TB] FAIL edge hop%0d cyc%0d: got x=%0d y=%0d rc=%0d/%0d flags=%b, expected x=%0d y=%0d rc=%0d/%0d flags=%b",
                             h, i, got_o.x, got_o.y, got_o.row, got_o.col, got_o.flags,
                             exp_o.x, exp_o.y, exp_o.row, exp_o.col, exp_o.flags);
                end
                if (h == 3 && i == 30) begin
                    n_vec++;
                    if (qbert_y !== 10'd1023 || qbert_x !== 11'd250) begin
                        n_miss++;
                        $display("[TB] FAIL fall_sat: got (%0d,%0d), expected (250,1023)", qbert_x, qbert_y);
                    end
                end
            end
            if (h == 2) begin
                n_vec++;
                if (qbert_x !== 11'd250 || qbert_y !== 10'd740 || cube_row !== 3'd3) begin
                    n_miss++;
                    $display("[TB] FAIL row3: got (%0d,%0d) row=%0d, expected (250,740) row=3", qbert_x, qbert_y, cube_row);
                end
            end
        end
    endtask

    task automatic test_tick_coincident();
        for (int i = 0; i < 19; i++) begin
            applyStimulus(i == 0, i == 1, DOWN_LEFT, (i == 1) || ((i > 1) && (i % 2 == 1)));
            exp_o = sb.pop_front(); got_o = dut_obs(); n_vec++;
            if (got_o !== exp_o) begin
                n_miss++;
                $display("[TB] FAIL coincide cyc%0d: got x=%0d y=%0d rc=%0d/%0d flags=%b, expected x=%0d y=%0d rc=%0d/%0d flags=%b",
                         i, got_o.x, got_o.y, got_o.row, got_o.col, got_o.flags,
                         exp_o.x, exp_o.y, exp_o.row, exp_o.col, exp_o.flags);
            end
            if (i == 1) begin
                n_vec++;
                if (qbert_x !== 11'd400 || qbert_y !== 10'd290 || busy !== 1'b1) begin
                    n_miss++;
                    $display("[TB] FAIL coincide_accept: got (%0d,%0d) busy=%b, expected (400,290) busy=1", qbert_x, qbert_y, busy);
                end
            end
            if (i == 17) begin
                n_vec++;
                if (landed !== 1'b1 || qbert_x !== 11'd350 || qbert_y !== 10'd440) begin
                    n_miss++;
                    $display("[TB] FAIL coincide_land: got landed=%b (%0d,%0d), expected landed=1 (350,440)", landed, qbert_x, qbert_y);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hop();
        for (int i = 0; i < 30; i++) begin
            applyStimulus((i == 0) || (i == 8), (i >= 1) && (i <= 8), (i == 1) ? DOWN_RIGHT : UP_LEFT,
                          (i > 1) && (i % 2 == 1));
            exp_o = sb.pop_front(); got_o = dut_obs(); n_vec++;
            if (got_o !== exp_o) begin
                n_miss++;
                $display("[TB] FAIL midreset cyc%0d: got x=%0d y=%0d rc=%0d/%0d flags=%b, expected x=%0d y=%0d rc=%0d/%0d flags=%b",
                         i, got_o.x, got_o.y, got_o.row, got_o.col, got_o.flags,
                         exp_o.x, exp_o.y, exp_o.row, exp_o.col, exp_o.flags);
            end
            if (i == 8) begin
                n_vec++;
                if (qbert_x !== 11'd400 || qbert_y !== 10'd290 || cmd_ready !== 1'b1 || landed !== 1'b0) begin
                    n_miss++;
                    $display("[TB] FAIL midreset_home: got (%0d,%0d) ready=%b landed=%b, expected (400,290) ready=1 landed=0",
                             qbert_x, qbert_y, cmd_ready, landed);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        reset = 1'b1;
        frame_tick = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir = 2'd0;
        model_step(1'b1, 1'b0, 0, 1'b0);
        test_reset();
        test_hop();
        test_fall();
        test_fall_saturate();
        test_tick_coincident();
        test_reset_mid_hop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
